// File: rtl/lsu.sv
// Load/store unit: accepts one load/store per handshake and drives a byte-addressed data memory.
// Define LSU_MISALIGNED_EN to split misaligned H/HU/W accesses into byte accesses instead of faulting.
module lsu #(
    parameter int unsigned MEMORY_SIZE = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_data_mask,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state, state_next;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] op_data;
    logic        op_fault;
    logic [1:0]  op_mask;
    logic [31:0] load_ext;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_fault;
    logic [2:0]  req_size;
    logic [32:0] req_end;

`ifdef LSU_MISALIGNED_EN
    logic [1:0]  byte_idx;
    logic [1:0]  byte_last;

    always_comb begin
        case (op_funct3[1:0])
            2'b00:   byte_last = 2'd0;
            2'b01:   byte_last = 2'd1;
            default: byte_last = 2'd3;
        endcase
    end
`endif

    // Request decode: legality, bounds (33-bit so the end address cannot wrap) and alignment.
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd1;
        endcase
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
        req_end        = {1'b0, req_addr} + 33'(req_size);
        req_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGNED_EN
        req_fault = !req_legal || (req_end > 33'(MEMORY_SIZE));
`else
        req_fault = !req_legal || (req_end > 33'(MEMORY_SIZE)) || req_misaligned;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_addr   <= 32'd0;
            op_wdata  <= 32'd0;
            op_data   <= 32'd0;
            op_fault  <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            byte_idx  <= 2'd0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                op_we     <= req_we;
                op_funct3 <= req_funct3;
                op_addr   <= req_addr;
                op_wdata  <= req_wdata;
                op_fault  <= req_fault;
                op_data   <= 32'd0;
`ifdef LSU_MISALIGNED_EN
                byte_idx  <= 2'd0;
`endif
            end
            if (state == ACCESS && !op_we) begin
                op_data <= mem_read_data;
            end
`ifdef LSU_MISALIGNED_EN
            if (state == SPLIT) begin
                if (!op_we) begin
                    op_data[{byte_idx, 3'b000} +: 8] <= mem_read_data[7:0];
                end
                byte_idx <= byte_idx + 2'd1;
            end
`endif
        end
    end

    always_comb begin
        case (op_funct3[1:0])
            2'b00:   op_mask = 2'b01;
            2'b01:   op_mask = 2'b10;
            default: op_mask = 2'b11;
        endcase
        case (op_funct3)
            3'b000:  load_ext = {{24{op_data[7]}}, op_data[7:0]};
            3'b001:  load_ext = {{16{op_data[15]}}, op_data[15:0]};
            3'b100:  load_ext = {24'd0, op_data[7:0]};
            3'b101:  load_ext = {16'd0, op_data[15:0]};
            default: load_ext = op_data;
        endcase
    end

    // NOTE: every output gets a default first (no latches); memory strobes decode from state only,
    // so the asynchronous return to IDLE on reset drops them before the next edge.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'd0;
        resp_fault     = 1'b0;
        mem_addr       = 32'd0;
        mem_write_data = 32'd0;
        mem_data_mask  = 2'b00;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
`ifdef LSU_MISALIGNED_EN
                    state_next = req_fault ? RESP : (req_misaligned ? SPLIT : ACCESS);
`else
                    state_next = req_fault ? RESP : ACCESS;
`endif
                end
            end
            ACCESS: begin
                mem_addr       = op_addr;
                mem_data_mask  = op_mask;
                mem_write_en   = op_we;
                mem_read_en    = !op_we;
                mem_write_data = op_we ? op_wdata : 32'd0;
                state_next     = RESP;
            end
`ifdef LSU_MISALIGNED_EN
            SPLIT: begin
                mem_addr       = op_addr + {30'd0, byte_idx};
                mem_data_mask  = 2'b01;
                mem_write_en   = op_we;
                mem_read_en    = !op_we;
                mem_write_data = op_we ? {24'd0, op_wdata[{byte_idx, 3'b000} +: 8]} : 32'd0;
                if (byte_idx == byte_last) begin
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = op_fault;
                resp_rdata = (op_fault || op_we) ? 32'd0 : load_ext;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized requests against a byte-array model.
module tb_lsu;

    localparam int MEM_SIZE = 2048;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [1:0]  mem_data_mask;
    logic        mem_write_en, mem_read_en;

    always #5 clk = ~clk;

    lsu #(.MEMORY_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_data_mask(mem_data_mask),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
    );

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // Environment memory: combinational read, synchronous write, plus a write log.
    logic [7:0]  mem [MEM_SIZE];
    logic [7:0]  ref_mem [MEM_SIZE];
    bit          mem_init_done = 1'b0;
    int          n_wr = 0, n_rd = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    logic [1:0]  wr_mask_q[$];

    function automatic int mask_bytes(logic [1:0] m);
        return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : (m == 2'b11) ? 4 : 0;
    endfunction

    always_comb begin
        logic [31:0] idx;
        mem_read_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            idx = mem_addr + 32'(k);
            if (k < mask_bytes(mem_data_mask) && idx < MEM_SIZE)
                mem_read_data[8*k +: 8] = mem[idx[10:0]];
        end
    end

    always @(posedge clk) begin
        logic [31:0] idx;
        if (!mem_init_done) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_byte(i);
            mem_init_done <= 1'b1;
        end
        if (mem_write_en) begin
            n_wr++;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_write_data);
            wr_mask_q.push_back(mem_data_mask);
            for (int k = 0; k < 4; k++) begin
                idx = mem_addr + 32'(k);
                if (k < mask_bytes(mem_data_mask) && idx < MEM_SIZE)
                    mem[idx[10:0]] <= mem_write_data[8*k +: 8];
            end
        end
        if (mem_read_en) n_rd++;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] last_rdata;
    logic        last_fault;
    int          wq0;

    // One request through the handshake, with expectations derived from the byte-array model.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold, input bit early, input string tag);
        int size, exp_lat, k, wr0, rd0, exp_acc;
        bit legal, mis, fault, split;
        longint v;
        logic [31:0] exp_data;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis   = (addr % size) != 0;
        fault = !legal || (longint'(addr) + size > MEM_SIZE) || (mis && !MIS_EN);
        split = !fault && mis;
        exp_data = 32'd0;
        if (!fault && !we) begin
            v = 0;
            for (int b = 0; b < size; b++) v += longint'(ref_mem[int'(addr) + b]) << (8 * b);
            if (f3 == 3'd0 && v >= 128) v -= 256;
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
            exp_data = 32'(v);
        end
        if (!fault && we)
            for (int b = 0; b < size; b++) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
        exp_lat = fault ? 0 : (split ? size : 1);
        exp_acc = fault ? 0 : (split ? size : 1);

        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        wr0 = n_wr; rd0 = n_rd; wq0 = wr_addr_q.size();
        resp_ready = early;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 8) begin @(posedge clk); #1; k++; end
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " fault"}, 32'(resp_fault), 32'(fault));
        check({tag, " rdata"}, resp_rdata, exp_data);
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        if (!early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
                check({tag, " hold_rdata"}, resp_rdata, exp_data);
                check({tag, " hold_ready_en"}, 32'({req_ready, mem_write_en, mem_read_en}), 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, " done"}, 32'({resp_valid, req_ready}), 32'b01);
        check({tag, " n_write"}, 32'(n_wr - wr0), we ? 32'(exp_acc) : 32'd0);
        check({tag, " n_read"}, 32'(n_rd - rd0), we ? 32'd0 : 32'(exp_acc));
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        int r;
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_byte(i);
        #12;
        check("rst_ctl", 32'({req_ready, resp_valid, resp_fault, mem_write_en, mem_read_en, mem_data_mask}), 32'd0);
        check("rst_bus", mem_addr | mem_write_data | resp_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);

        run_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1'b0, "sw100");
        check("sw100 log_mask", 32'(wr_mask_q[wq0]), 32'd3);
        check("sw100 log_addr", wr_addr_q[wq0], 32'h100);
        run_req(1'b0, 3'd2, 32'h100, 32'd0, 0, 1'b0, "lw100");
        check("lw100 plan", last_rdata, 32'hDEADBEEF);
        run_req(1'b0, 3'd0, 32'h103, 32'd0, 1, 1'b0, "lb103");
        check("lb103 plan", last_rdata, 32'hFFFFFFDE);
        run_req(1'b0, 3'd4, 32'h103, 32'd0, 0, 1'b1, "lbu103");
        check("lbu103 plan", last_rdata, 32'h000000DE);
        run_req(1'b0, 3'd1, 32'h102, 32'd0, 0, 1'b0, "lh102");
        check("lh102 plan", last_rdata, 32'hFFFFDEAD);
        run_req(1'b0, 3'd5, 32'h100, 32'd0, 0, 1'b0, "lhu100");
        check("lhu100 plan", last_rdata, 32'h0000BEEF);

        run_req(1'b1, 3'd2, 32'h201, 32'h11223344, 0, 1'b0, "sw201");
        check("sw201 plan_fault", 32'(last_fault), 32'(!MIS_EN));
        if (MIS_EN) begin
            for (int j = 0; j < 4; j++) begin
                check("sw201 split_addr", wr_addr_q[wq0 + j], 32'h201 + 32'(j));
                check("sw201 split_data", wr_data_q[wq0 + j], 32'h44 - 32'(j) * 32'h11);
                check("sw201 split_mask", 32'(wr_mask_q[wq0 + j]), 32'd1);
            end
        end
        run_req(1'b0, 3'd2, 32'h201, 32'd0, 0, 1'b0, "lw201");
        check("lw201 plan", last_rdata, MIS_EN ? 32'h11223344 : 32'd0);
        run_req(1'b0, 3'd1, 32'h101, 32'd0, 0, 1'b1, "lh101");

        run_req(1'b0, 3'd2, 32'h7FE, 32'd0, 0, 1'b0, "lw7fe");
        check("lw7fe plan_fault", 32'(last_fault), 32'd1);
        run_req(1'b0, 3'd3, 32'h40, 32'd0, 0, 1'b0, "ld_f3_011");
        run_req(1'b1, 3'd4, 32'h40, 32'h5A, 0, 1'b0, "st_f3_100");
        run_req(1'b0, 3'd0, 32'h7FF, 32'd0, 0, 1'b0, "lb7ff");
        check("lb7ff plan_fault", 32'(last_fault), 32'd0);
        run_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 0, 1'b0, "lw_wrap");
        run_req(1'b0, 3'd2, 32'h100, 32'd0, 3, 1'b0, "backpressure");

        // Reset in the middle of a store: already committed bytes stay, the rest are untouched.
        req_we = 1'b1; req_funct3 = 3'd2; req_wdata = 32'hAABBCCDD;
        req_addr = MIS_EN ? 32'h301 : 32'h300;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (MIS_EN) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_ctl", 32'({req_ready, resp_valid, resp_fault, mem_write_en, mem_read_en, mem_data_mask}), 32'd0);
        check("midrst_bus", mem_addr | mem_write_data | resp_rdata, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        if (MIS_EN) begin
            ref_mem[12'h301] = 8'hDD;
            ref_mem[12'h302] = 8'hCC;
        end
        for (int a = 12'h300; a < 12'h306; a++)
            check("midrst_mem", 32'(mem[a]), 32'(ref_mem[a]));
        @(posedge clk); #1;
        check("midrst_ready", 32'({req_ready, resp_valid}), 32'b10);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0:       req_addr = 32'($urandom_range(2040, 2052));
                1:       req_addr = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: req_addr = 32'($urandom_range(32'h100, 32'h13F));
            endcase
            run_req(1'($urandom_range(0, 1)),
                    (r < 14) ? legal_f3[r % 5] : ((r == 14) ? 3'd3 : 3'($urandom_range(6, 7))),
                    req_addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
